// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - word-wide backing-memory request/acknowledge bus
interface data_cache_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
module data_cache #(
    parameter int SETS_LOG2  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]            mem_type_i,
    input  logic                  mem_sign_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    data_cache_if.master          mem
);
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = 32 - SETS_LOG2 - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

    state_t                  state;
    logic [SETS-1:0]         valid;
    logic [TAG_W-1:0]        tag_mem  [SETS];
    logic [DATA_WIDTH-1:0]   data_mem [SETS];

    logic                    req_q;
    logic                    we_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              be_q;

    logic [SETS_LOG2-1:0]    idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   line;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [3:0]              st_be;
    logic [31:0]             st_wdata;
    logic [31:0]             merged;

    assign idx  = addr_i[SETS_LOG2+1:2];
    assign tag  = addr_i[31:SETS_LOG2+2];
    assign hit  = valid[idx] && (tag_mem[idx] == tag);
    assign line = data_mem[idx];

    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_be_o    = be_q;

    always_comb begin
        byte_sel = line[{addr_i[1:0], 3'b000} +: 8];
        half_sel = addr_i[1] ? line[31:16] : line[15:0];
        case (mem_type_i)
            2'b00:   rdata_o = {{24{mem_sign_i & byte_sel[7]}}, byte_sel};
            2'b01:   rdata_o = {{16{mem_sign_i & half_sel[15]}}, half_sel};
            default: rdata_o = line;
        endcase
    end

    // Stall is combinational in IDLE so a miss or store holds the core in its first cycle.
    always_comb begin
        case (state)
            IDLE:             stall_o = req_i && (we_i || !hit);
            RD_MISS, WR_THRU: stall_o = 1'b1;
            default:          stall_o = 1'b0;
        endcase
    end

    always_comb begin
        case (mem_type_i)
            2'b00: begin
                st_be    = 4'b0001 << addr_i[1:0];
                st_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {addr_i[1], 1'b0};
                st_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_i;
            end
        endcase
    end

    always_comb begin
        merged = line;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && we_i) begin
                        state   <= WR_THRU;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        wdata_q <= st_wdata;
                        be_q    <= st_be;
                    end else if (req_i && !hit) begin
                        state   <= RD_MISS;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        be_q    <= 4'b1111;
                    end
                end
                RD_MISS: begin
                    if (mem.mem_ack_i) begin
                        valid[idx] <= 1'b1;
                        req_q      <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR_THRU: begin
                    if (mem.mem_ack_i) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (!rst && mem.mem_ack_i) begin
            if (state == RD_MISS) begin
                tag_mem[idx]  <= tag;
                data_mem[idx] <= mem.mem_rdata_i;
            end else if (state == WR_THRU && hit) begin
                data_mem[idx] <= merged;
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed and randomized check of data_cache against a reference model
module tb_data_cache;
    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mtype;
    logic        msign;
    logic [31:0] rdata;
    logic        stall;

    data_cache_if mif ();

    data_cache #(.SETS_LOG2(6), .DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst        (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .mem_type_i (mtype),
        .mem_sign_i (msign),
        .rdata_o    (rdata),
        .stall_o    (stall),
        .mem        (mif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          tests;
    int          fails;
    int unsigned mem_lat;
    int unsigned inject_cnt;
    logic [31:0] bmem    [bit [29:0]];
    logic [31:0] ref_mem [bit [29:0]];
    int unsigned model_line [int];

    function automatic logic [31:0] init_word(bit [29:0] w);
        if (w == 30'h40) return 32'hDEADBEEF;
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] ref_word(bit [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] word, logic [31:0] a, logic [1:0] t, bit s);
        logic [31:0] v;
        case (t)
            2'b00: begin
                v = (word >> (a[1:0] * 8)) & 32'hFF;
                if (s && v[7]) v = v - 32'h100;
            end
            2'b01: begin
                v = (word >> (a[1] ? 16 : 0)) & 32'hFFFF;
                if (s && v[15]) v = v - 32'h10000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic [31:0] a, logic [1:0] t);
        case (t)
            2'b00:   return 4'(1 << a[1:0]);
            2'b01:   return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(logic [31:0] d, logic [1:0] t);
        case (t)
            2'b00:   return {24'h0, d[7:0]} * 32'h01010101;
            2'b01:   return {16'h0, d[15:0]} * 32'h00010001;
            default: return d;
        endcase
    endfunction

    // Backing memory: acknowledges after mem_lat cycles of mem_req_o, plus injected stray acks.
    initial begin : responder
        int unsigned hold;
        int unsigned inject_done;
        bit [29:0]   w;
        logic [31:0] word;
        hold = 0;
        inject_done = 0;
        mif.mem_ack_i = 1'b0;
        mif.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mif.mem_ack_i = 1'b0;
            if (rst) begin
                hold = 0;
            end else if (inject_done != inject_cnt) begin
                inject_done = inject_cnt;
                mif.mem_ack_i = 1'b1;
                mif.mem_rdata_i = 32'hBAD0BAD0;
            end else if (mif.mem_req_o) begin
                hold++;
                if (hold >= mem_lat) begin
                    hold = 0;
                    mif.mem_ack_i = 1'b1;
                    w = mif.mem_addr_o[31:2];
                    word = bmem.exists(w) ? bmem[w] : init_word(w);
                    if (mif.mem_we_o) begin
                        for (int i = 0; i < 4; i++)
                            if (mif.mem_be_o[i]) word[8*i +: 8] = mif.mem_wdata_o[8*i +: 8];
                        bmem[w] = word;
                    end else begin
                        mif.mem_rdata_i = word;
                    end
                end
            end else begin
                hold = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] t, input bit s,
                         output int n_stall, output logic [31:0] rd,
                         output logic [31:0] m_addr, output logic [3:0] m_be,
                         output logic [31:0] m_wd, output logic m_we,
                         output bit stable, output bit timeout);
        bit saw_req;
        bit done;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; mtype = t; msign = s;
        n_stall = 0; rd = 'x; m_addr = 'x; m_be = 'x; m_wd = 'x; m_we = 'x;
        stable = 1'b1; saw_req = 1'b0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (!stall) begin
                rd = rdata;
                done = 1'b1;
            end else begin
                n_stall++;
                if (mif.mem_req_o) begin
                    if (saw_req && (m_addr !== mif.mem_addr_o || m_be !== mif.mem_be_o ||
                                    m_we !== mif.mem_we_o ||
                                    (m_we && m_wd !== mif.mem_wdata_o)))
                        stable = 1'b0;
                    m_addr = mif.mem_addr_o; m_be = mif.mem_be_o;
                    m_wd = mif.mem_wdata_o;  m_we = mif.mem_we_o;
                    saw_req = 1'b1;
                end
                @(negedge clk);
            end
        end
        timeout = !done;
    endtask

    task automatic check_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] t, input bit s,
                            output logic [31:0] rd, output logic [31:0] m_addr, output int n_stall);
        int          li;
        int unsigned wa;
        bit          exp_hit;
        logic [3:0]  m_be, eb;
        logic [31:0] m_wd, ew, word;
        logic        m_we;
        bit          stable, timeout;
        wa = a >> 2;
        li = int'(wa % 64);
        exp_hit = model_line.exists(li) && model_line[li] == wa;
        do_op(w, a, d, t, s, n_stall, rd, m_addr, m_be, m_wd, m_we, stable, timeout);
        chk("timeout", 32'(timeout), 0);
        if (w) begin
            eb = ref_be(a, t);
            ew = ref_wd(d, t);
            chk("st_stall", n_stall, mem_lat + 1);
            chk("st_we", 32'(m_we), 1);
            chk("st_addr", m_addr, {a[31:2], 2'b00});
            chk("st_be", 32'(m_be), 32'(eb));
            chk("st_wdata", m_wd, ew);
            chk("st_stable", 32'(stable), 1);
            word = ref_word(wa[29:0]);
            for (int i = 0; i < 4; i++) if (eb[i]) word[8*i +: 8] = ew[8*i +: 8];
            ref_mem[wa[29:0]] = word;
        end else if (exp_hit) begin
            chk("ld_hit_stall", n_stall, 0);
            chk("ld_hit_rdata", rd, ref_load(ref_word(wa[29:0]), a, t, s));
        end else begin
            chk("ld_miss_stall", n_stall, mem_lat + 1);
            chk("ld_miss_we", 32'(m_we), 0);
            chk("ld_miss_addr", m_addr, {a[31:2], 2'b00});
            chk("ld_miss_be", 32'(m_be), 32'hF);
            chk("ld_miss_stable", 32'(stable), 1);
            chk("ld_miss_rdata", rd, ref_load(ref_word(wa[29:0]), a, t, s));
            model_line[li] = wa;
        end
    endtask

    initial begin : main
        logic [31:0] rd, ma;
        int          ns;
        bit          rw;
        logic [31:0] ra;
        tests = 0; fails = 0; mem_lat = 3; inject_cnt = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mtype = 2'b10; msign = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(mif.mem_req_o), 0);
        chk("rst_we", 32'(mif.mem_we_o), 0);
        chk("rst_be", 32'(mif.mem_be_o), 0);
        chk("rst_addr", mif.mem_addr_o, 0);
        chk("rst_wdata", mif.mem_wdata_o, 0);
        chk("rst_stall", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;

        // Cold load with three-cycle memory latency, then a hit reload.
        check_op(0, 32'h100, 0, 2'b10, 0, rd, ma, ns);
        chk("cold_stall4", ns, 4);
        chk("cold_addr", ma, 32'h100);
        chk("cold_rdata", rd, 32'hDEADBEEF);
        check_op(0, 32'h100, 0, 2'b10, 0, rd, ma, ns);
        chk("reload_stall", ns, 0);
        chk("reload_rdata", rd, 32'hDEADBEEF);

        check_op(0, 32'h103, 0, 2'b00, 1, rd, ma, ns);
        chk("lb_103", rd, 32'hFFFFFFDE);
        check_op(0, 32'h101, 0, 2'b00, 0, rd, ma, ns);
        chk("lbu_101", rd, 32'h000000BE);
        check_op(0, 32'h102, 0, 2'b01, 1, rd, ma, ns);
        chk("lh_102", rd, 32'hFFFFDEAD);
        check_op(0, 32'h100, 0, 2'b01, 0, rd, ma, ns);
        chk("lhu_100", rd, 32'h0000BEEF);

        check_op(1, 32'h101, 32'h55, 2'b00, 0, rd, ma, ns);
        check_op(0, 32'h100, 0, 2'b10, 0, rd, ma, ns);
        chk("sb_merge_stall", ns, 0);
        chk("sb_merge_rdata", rd, 32'hDEAD55EF);

        check_op(1, 32'h200, 32'h12345678, 2'b10, 0, rd, ma, ns);
        check_op(0, 32'h200, 0, 2'b10, 0, rd, ma, ns);
        chk("no_alloc_addr", ma, 32'h200);
        chk("no_alloc_rdata", rd, 32'h12345678);

        // Conflict on index 0.
        check_op(0, 32'h100, 0, 2'b10, 0, rd, ma, ns);
        chk("conf_a0", ma, 32'h100);
        check_op(0, 32'h200, 0, 2'b10, 0, rd, ma, ns);
        chk("conf_a1", ma, 32'h200);
        check_op(0, 32'h100, 0, 2'b10, 0, rd, ma, ns);
        chk("conf_a2", ma, 32'h100);

        // Reset asserted while a read miss is outstanding.
        mem_lat = 20;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h300; mtype = 2'b10; msign = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("mid_req_high", 32'(mif.mem_req_o), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(mif.mem_req_o), 0);
        chk("mid_rst_be", 32'(mif.mem_be_o), 0);
        chk("mid_rst_addr", mif.mem_addr_o, 0);
        chk("mid_rst_stall_req", 32'(stall), 1);
        req = 1'b0;
        #1 chk("mid_rst_stall_idle", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        model_line.delete();
        inject_cnt++;
        repeat (3) @(negedge clk);
        #1;
        chk("late_ack_req", 32'(mif.mem_req_o), 0);
        chk("late_ack_stall", 32'(stall), 0);
        mem_lat = 2;
        check_op(0, 32'h300, 0, 2'b10, 0, rd, ma, ns);
        chk("post_rst_miss_addr", ma, 32'h300);
        check_op(0, 32'h100, 0, 2'b10, 0, rd, ma, ns);
        chk("post_rst_100_stall", ns, 3);

        // Randomized mix over a few tags and indices so hits, conflicts and merges occur.
        for (int n = 0; n < 120; n++) begin
            mem_lat = $urandom_range(1, 4);
            rw = ($urandom_range(0, 2) == 0);
            ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            check_op(rw, ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, ma, ns);
        end

        @(negedge clk);
        req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's load/store path and a slower backing data memory.
- Core side takes the same address, store-data, access-type and sign controls the core already uses for data memory, and adds a stall output.
- Memory side is a word-wide request/acknowledge port with byte enables.
- Read hits cost zero extra cycles. Misses and all stores stall the core until the backing memory acknowledges.

Parameters:
- SETS_LOG2, 6, log2 of line count; one 32-bit word per line.
- DATA_WIDTH, 32, word width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  core load/store request valid.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- mem_type_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_sign_i  in  1  1 = sign-extend loads, 0 = zero-extend.
- rdata_o  out  32  extracted and extended load data.
- stall_o  out  1  core must hold its request and PC.
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  backing-memory write.
- mem_addr_o  out  32  word-aligned address, [1:0] = 0.
- mem_wdata_o  out  32  lane-aligned store data.
- mem_be_o  out  4  byte enables.
- mem_rdata_i  in  32  backing read word.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Address split: offset [1:0], index [SETS_LOG2+1:2], tag [31:SETS_LOG2+2].
- Per line storage: valid bit, tag, 32-bit data word. hit = valid[index] && tag match.
- Alignment: half ignores addr[0]; word ignores addr[1:0]. Misaligned accesses are not trapped.
- Load extraction: select byte lane addr[1:0] or half lane addr[1]; extend per mem_sign_i. rdata_o is combinational from the line indexed by addr_i.
- FSM states: IDLE, RD_MISS, WR_THRU, RESP.
  - IDLE, no req: stall_o=0, mem_req_o=0.
  - IDLE, load hit: stall_o=0, rdata_o valid in the same cycle.
  - IDLE, load miss: stall_o=1 combinationally; go to RD_MISS.
  - IDLE, store (hit or miss): stall_o=1; go to WR_THRU.
  - RD_MISS: mem_req_o=1, mem_we_o=0, mem_be_o=1111, mem_addr_o = {addr_i[31:2],2'b00}; stall_o=1.
  - RD_MISS, ack: write tag, data = mem_rdata_i and valid=1; go to RESP.
  - WR_THRU: mem_req_o=1, mem_we_o=1.
    - byte: mem_be_o = 0001 << addr[1:0], mem_wdata_o = wdata_i[7:0] replicated ×4.
    - half: mem_be_o = 0011 << {addr[1],1'b0}, mem_wdata_o = wdata_i[15:0] replicated ×2.
    - word: mem_be_o = 1111, mem_wdata_o = wdata_i.
    - stall_o=1.
  - WR_THRU, ack: if hit, merge enabled bytes into the line, tag and valid unchanged; if miss, cache unchanged. Go to RESP.
  - RESP: lasts exactly one cycle; stall_o=0, mem_req_o=0, rdata_o from the updated line; the core's request retires. Next state is IDLE regardless of req_i.
- Handshake:
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are registered on entering RD_MISS/WR_THRU and held stable until the cycle mem_ack_i is sampled high.
  - mem_req_o drops in the next cycle.
  - mem_ack_i outside RD_MISS/WR_THRU is ignored.
  - No timeout.
- Core contract: addr_i, we_i, wdata_i and mem_type_i are stable while stall_o=1.
- Reset (asserted at any time, including mid-miss or mid-write):
  - All valid bits cleared; state to IDLE.
  - mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0 immediately.
  - stall_o = combinational function of req_i and hit; reads 0 while reset held with req_i=0.
  - rdata_o is don't-care until the first fill.
  - A pending memory transaction is abandoned; a late ack is ignored.
- Latency: load hit 0 extra cycles; load miss and store each N+1 stall cycles, where N is the number of cycles from mem_req_o rising to mem_ack_i.

Test Plan:
- Cold load: reset, then word load at 0x100; memory returns 0xDEADBEEF with ack 3 cycles after req. Required: stall_o high 4 cycles, mem_addr_o=0x100, be=1111. RESP cycle rdata_o=0xDEADBEEF. Reload of 0x100 gives stall_o=0 and the same data.
- Sub-word extraction on the filled line 0x100 = 0xDEADBEEF:
  - LB 0x103, sign=1 → 0xFFFFFFDE.
  - LBU 0x101 → 0x000000BE.
  - LH 0x102, sign=1 → 0xFFFFDEAD.
  - LHU 0x100 → 0x0000BEEF.
  - All with zero stall.
- Store hit: SB 0x101 with wdata 0x55. Required: mem_be_o=0010, mem_wdata_o=0x55555555, mem_we_o=1. After ack, LW 0x100 hits and returns 0xDEAD55EF.
- Store miss: SW 0x200 with 0x12345678. Required: write-through with be=1111. Next LW 0x200 misses and issues a read request (no allocate).
- Conflict: with SETS_LOG2=6, load 0x100, then 0x200 (same index 0), then 0x100. Required: all three miss; mem_addr_o sequence 0x100, 0x200, 0x100.
- Reset mid-miss: assert rst during RD_MISS before ack. Required: mem_req_o falls the same cycle. A late ack is ignored. Reload of the same address misses again.
